chunked_addsub: RTL
===================

# chunked_addsub

Sequential N-bit adder/subtractor that computes its result over N/W cycles by iterating one W-bit ripple-carry slice across the operands, least-significant chunk first. It replaces the flat 32-stage combinational ripple with a parametrised, area-light datapath. The block sits behind a valid/ready handshake on both sides, so it can be dropped into the ALU datapath or a multi-cycle execution unit. It reports unsigned carry/borrow, signed overflow and zero.

## Interface
- N, default 32: operand and result width; N must be a multiple of W.
- W, default 8: slice width processed per cycle; 1 ≤ W ≤ N.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  operands and mode present.
- in_ready  out  1  block can accept an operation.
- a  in  N  operand A, unsigned or two's complement.
- b  in  N  operand B.
- sub  in  1  selects the operation: 0 = a+b, 1 = a−b.
- out_valid  out  1  result registers hold a completed result.
- out_ready  in  1  consumer accepts the result.
- s  out  N  sum or difference, mod 2^N.
- cout  out  1  carry out of bit N−1; for subtract, 1 = no borrow (a ≥ b unsigned).
- ovf  out  1  signed overflow: carry into bit N−1 XOR carry out of bit N−1.
- zero  out  1  s == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid, latch a into opA and (b XOR {N{sub}}) into opB, set carry register to sub, clear slice index k to 0, and go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, add slice k: opA[kW+W−1:kW] + opB slice + carry. Write the W-bit result into the result register slice k and register the slice carry-out.
  - On the final slice (k = N/W−1), also capture the carry into bit N−1. Load s, cout, ovf and zero from the completed result, then go to DONE. Otherwise increment k.
- DONE:
  - out_valid=1, in_ready=0, outputs stable.
  - On out_ready, go to IDLE. A new operation is not accepted in the same cycle.
- s, cout, ovf and zero change only on the RUN→DONE transition. They hold their last value in IDLE and RUN.
- Inputs are ignored outside the IDLE accept cycle, so a and b may change freely during RUN.
- The slice index is ceil(log2(N/W)) bits wide, minimum 1. When W=N, RUN lasts exactly one cycle.

## Timing
- Reset (rst_n=0 at a rising edge) takes priority over everything, including mid-RUN or mid-DONE. After that edge: state=IDLE, in_ready=1, out_valid=0, s=0, cout=0, ovf=0, zero=0, k=0. Any in-flight operation is discarded without a result.
- Latency:
  - Accept edge T0; slices processed at edges T1…T(N/W).
  - out_valid is high in the cycle following edge T(N/W), i.e. N/W cycles after the accept edge.
- Throughput: one operation per N/W+2 cycles with out_ready held high (accept, N/W RUN cycles, 1 DONE cycle).
- Backpressure: DONE persists indefinitely while out_ready=0, with every output unchanged.
- out_ready in IDLE or RUN has no effect.

## Structure
- Shared package `addsub_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - `SLICES = N/W` helper function.
  - index width function.
- One sub-module, `ripple_slice #(W)`: a combinational W-bit ripple-carry adder built from the existing full-adder cell. Ports: a, b, cin, s, cout, plus c_msb (carry into the top bit), used for ovf.
- Top level contains the FSM, operand/result shift-free registers indexed by k, and flag logic.
- Elaboration-time check: fail if N % W ≠ 0 or W < 1.

## Test plan
- N=32, W=8, a=13, b=12, sub=1 → out_valid 4 cycles after accept; s=1, cout=1, ovf=0, zero=0.
- a=12, b=13, sub=1 → s=32'hFFFF_FFFF, cout=0, ovf=0, zero=0.
- a=32'h7FFF_FFFF, b=1, sub=0 → s=32'h8000_0000, cout=0, ovf=1. Also a=32'hFFFF_FFFF, b=1, sub=0 → s=0, cout=1, ovf=0, zero=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, with in_valid=1 and changing a/b throughout.
  - Outputs and out_valid stay stable, and in_ready stays 0.
  - Release out_ready: IDLE next cycle, and the new operation is accepted the cycle after.
- Reset mid-op: assert rst_n=0 at the edge after k=1. The next cycle shows IDLE, in_ready=1, out_valid=0 and all outputs 0, and no spurious out_valid follows.
- Parameter sweep (N,W) = (32,1), (32,32), (16,4) with 1000 random operands each. The result matches a+b or a−b mod 2^N, and cout, ovf and zero match the reference model. Latency is exactly N/W.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the chunked adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int slices(input int n, input int w);
        if (w < 1) begin
            return 1;
        end
        return n / w;
    endfunction

    // Slice-index width, never narrower than one bit even when a single slice covers N.
    function automatic int idx_width(input int n, input int w);
        int sl;
        sl = slices(n, w);
        return (sl <= 1) ? 1 : $clog2(sl);
    endfunction

endpackage

// File: rtl/chunked_addsub_ripple_slice.sv
// W-bit ripple-carry slice assembled from full-adder cells; also exposes the
// carry into its top bit so the caller can derive signed overflow.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb
);
    logic [W:0] c_s;

    assign c_s[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c_s[i]),
            .s   (s[i]),
            .cout(c_s[i+1])
        );
    end

    assign cout  = c_s[W];
    assign c_msb = c_s[W-1];
endmodule

// File: rtl/chunked_addsub.sv
// Sequential N-bit add/subtract: one W-bit ripple slice is reused over N/W
// cycles, least-significant chunk first, behind valid/ready handshakes.
module chunked_addsub
    import addsub_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);
    localparam int SLICES = slices(N, W);
    localparam int IDX_W  = idx_width(N, W);
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(SLICES - 1);

    if ((W < 1) || (N % W != 0)) begin : g_bad_params
        $error("chunked_addsub: N must be a positive multiple of W");
    end

    state_t             state_r;
    logic [N-1:0]       opa_r;
    logic [N-1:0]       opb_r;
    logic [N-1:0]       res_r;
    logic               carry_r;
    logic [IDX_W-1:0]   k_r;

    logic [W-1:0]       slice_a_s;
    logic [W-1:0]       slice_b_s;
    logic [W-1:0]       slice_sum_s;
    logic               slice_cout_s;
    logic               slice_cmsb_s;
    logic [N-1:0]       res_next_s;

    // Select the active operand chunk and merge the slice sum into the result image.
    always_comb begin
        slice_a_s  = opa_r[int'(k_r)*W +: W];
        slice_b_s  = opb_r[int'(k_r)*W +: W];
        res_next_s = res_r;
        res_next_s[int'(k_r)*W +: W] = slice_sum_s;
    end

    ripple_slice #(.W(W)) u_slice (
        .a    (slice_a_s),
        .b    (slice_b_s),
        .cin  (carry_r),
        .s    (slice_sum_s),
        .cout (slice_cout_s),
        .c_msb(slice_cmsb_s)
    );

    // Handshake FSM, slice iteration and registered result/flag outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            k_r       <= '0;
            opa_r     <= '0;
            opb_r     <= '0;
            res_r     <= '0;
            carry_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1: invert b here, seed the carry with sub.
                        opa_r    <= a;
                        opb_r    <= b ^ {N{sub}};
                        carry_r  <= sub;
                        k_r      <= '0;
                        in_ready <= 1'b0;
                        state_r  <= RUN;
                    end
                end
                RUN: begin
                    res_r   <= res_next_s;
                    carry_r <= slice_cout_s;
                    if (k_r == LAST_K) begin
                        s         <= res_next_s;
                        cout      <= slice_cout_s;
                        ovf       <= slice_cout_s ^ slice_cmsb_s;
                        zero      <= (res_next_s == '0);
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        k_r <= k_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end
endmodule
